// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package rename_pkg;

    localparam int DEF_FL_DEPTH    = 64;
    localparam int DEF_TAG_W       = 7;
    localparam int DEF_TAG_BASE    = 32;
    localparam int DEF_ALLOC_PORTS = 3;
    localparam int DEF_FREE_PORTS  = 3;
    localparam int DEF_NUM_CKPT    = 8;

    typedef logic [DEF_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/free_list_nport_if.sv
// Rename/commit-side bundle of the N-port free list: alloc, free and checkpoint controls.
interface free_list_nport_if
    import rename_pkg::*;
#(
    parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
    parameter int FREE_PORTS  = DEF_FREE_PORTS,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int CKPT_W      = $clog2(DEF_NUM_CKPT),
    parameter int CNT_W       = $clog2(DEF_FL_DEPTH) + 1
);

    logic [ALLOC_PORTS-1:0]             alloc_req;
    logic                               alloc_ready;
    logic [ALLOC_PORTS-1:0][TAG_W-1:0]  alloc_tag;
    logic [ALLOC_PORTS-1:0]             alloc_valid;
    logic [FREE_PORTS-1:0]              free_en;
    logic [FREE_PORTS-1:0][TAG_W-1:0]   free_tag;
    logic                               ckpt_save;
    logic [CKPT_W-1:0]                  ckpt_save_id;
    logic                               ckpt_restore;
    logic [CKPT_W-1:0]                  ckpt_restore_id;
    logic [CNT_W-1:0]                   count;
    logic                               empty;
    logic                               full;
    logic                               free_overflow;

    modport master (
        output alloc_req, free_en, free_tag,
               ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        input  alloc_ready, alloc_tag, alloc_valid,
               count, empty, full, free_overflow
    );

    modport slave (
        input  alloc_req, free_en, free_tag,
               ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        output alloc_ready, alloc_tag, alloc_valid,
               count, empty, full, free_overflow
    );

endinterface

// File: rtl/fl_port_compact.sv
// Prefix popcount of a per-port enable vector: each port gets the number of
// enabled ports below it (its slot offset), plus the total enabled count.
module fl_port_compact
    import rename_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
)(
    input  logic [N-1:0]            i_en,
    output logic [N-1:0][IDX_W-1:0] o_offset,
    output logic [IDX_W-1:0]        o_total
);

    // Running count, LSB port first, so the k-th set bit gets offset k.
    always_comb begin
        logic [IDX_W-1:0] w_acc;
        w_acc    = {IDX_W{1'b0}};
        o_offset = '0;
        for (int i = 0; i < N; i++) begin
            o_offset[i] = w_acc;
            w_acc       = w_acc + IDX_W'(i_en[i]);
        end
        o_total = w_acc;
    end

endmodule

// File: rtl/free_list_nport.sv
// N-port physical-tag free list: circular buffer of free tags with compacted
// multi-port alloc/free and head-pointer checkpoints for mispredict recovery.
module free_list_nport
    import rename_pkg::*;
#(
    parameter int FL_DEPTH    = DEF_FL_DEPTH,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int TAG_BASE    = DEF_TAG_BASE,
    parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
    parameter int FREE_PORTS  = DEF_FREE_PORTS,
    parameter int NUM_CKPT    = DEF_NUM_CKPT
)(
    input  logic               clk,
    input  logic               rst_n,
    free_list_nport_if.slave   bus
);

    localparam int AW     = $clog2(FL_DEPTH);
    localparam int PW     = AW + 1;
    localparam int AIDX_W = $clog2(ALLOC_PORTS + 1);
    localparam int FIDX_W = $clog2(FREE_PORTS + 1);

    logic [TAG_W-1:0] r_mem  [FL_DEPTH];
    logic [PW-1:0]    r_slot [NUM_CKPT];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic             r_overflow;

    logic [PW-1:0]    w_count;
    logic [PW-1:0]    w_head_nxt;
    logic [PW-1:0]    w_tail_nxt;
    logic [PW:0]      w_free_sum;
    logic             w_ready;
    logic             w_free_ovf;
    logic [AW-1:0]    w_aidx [ALLOC_PORTS];
    logic [AW-1:0]    w_fidx [FREE_PORTS];

    logic [ALLOC_PORTS-1:0][AIDX_W-1:0] w_aoff;
    logic [AIDX_W-1:0]                  w_atot;
    logic [FREE_PORTS-1:0][FIDX_W-1:0]  w_foff;
    logic [FIDX_W-1:0]                  w_ftot;

    fl_port_compact #(.N(ALLOC_PORTS), .IDX_W(AIDX_W)) u_alloc_compact (
        .i_en     (bus.alloc_req),
        .o_offset (w_aoff),
        .o_total  (w_atot)
    );

    fl_port_compact #(.N(FREE_PORTS), .IDX_W(FIDX_W)) u_free_compact (
        .i_en     (bus.free_en),
        .o_offset (w_foff),
        .o_total  (w_ftot)
    );

    // Occupancy and all-or-nothing alloc gate, from the pre-free count.
    always_comb begin
        w_count = r_tail - r_head;
        w_ready = (w_count >= PW'(w_atot));
    end

    // Compacted alloc grant: k-th requester reads mem[head+k], index wraps on low bits.
    always_comb begin
        bus.alloc_valid = '0;
        bus.alloc_tag   = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            w_aidx[i]          = r_head[AW-1:0] + AW'(w_aoff[i]);
            bus.alloc_valid[i] = bus.alloc_req[i] & w_ready & ~bus.ckpt_restore;
            if (bus.alloc_valid[i]) begin
                bus.alloc_tag[i] = r_mem[w_aidx[i]];
            end else begin
                bus.alloc_tag[i] = {TAG_W{1'b0}};
            end
        end
    end

    // Next head: a restore overrides any grant in the same cycle.
    always_comb begin
        if (bus.ckpt_restore) begin
            w_head_nxt = r_slot[bus.ckpt_restore_id];
        end else if (w_ready) begin
            w_head_nxt = r_head + PW'(w_atot);
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Free group sizing: an overflowing group is dropped whole and tail holds.
    always_comb begin
        w_free_sum = {1'b0, w_count} + (PW+1)'(w_ftot);
        w_free_ovf = (|bus.free_en) & (w_free_sum > (PW+1)'(FL_DEPTH));
        if (w_free_ovf) begin
            w_tail_nxt = r_tail;
        end else begin
            w_tail_nxt = r_tail + PW'(w_ftot);
        end
        for (int i = 0; i < FREE_PORTS; i++) begin
            w_fidx[i] = r_tail[AW-1:0] + AW'(w_foff[i]);
        end
    end

    // Status outputs derived from the registered pointers.
    always_comb begin
        bus.alloc_ready   = w_ready;
        bus.count         = w_count;
        bus.empty         = (w_count == {PW{1'b0}});
        bus.full          = (w_count == PW'(FL_DEPTH));
        bus.free_overflow = r_overflow;
    end

    // Head/tail pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= {PW{1'b0}};
            r_tail     <= PW'(FL_DEPTH);
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_overflow <= r_overflow | w_free_ovf;
        end
    end

    // Checkpoint slots capture the post-grant head; a concurrent restore suppresses the save.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_slot[i] <= {PW{1'b0}};
            end
        end else if (bus.ckpt_save && !bus.ckpt_restore) begin
            r_slot[bus.ckpt_save_id] <= w_head_nxt;
        end
    end

    // Tag storage: reset seeds entry i with TAG_BASE+i; returned tags land at tail+k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= TAG_W'(TAG_BASE + i);
            end
        end else begin
            for (int i = 0; i < FREE_PORTS; i++) begin
                if (bus.free_en[i] && !w_free_ovf) begin
                    r_mem[w_fidx[i]] <= bus.free_tag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_free_list_nport.sv
// Table-driven bench for free_list_nport with a scoreboard queue of expected outputs.
module tb_free_list_nport;
    import rename_pkg::*;

    typedef struct {
        logic [2:0] req;
        logic [2:0] fen;
        logic [6:0] ft0, ft1, ft2;
        logic       sv;
        logic [2:0] svid;
        logic       rs;
        logic [2:0] rsid;
        logic       e_rdy;
        logic [2:0] e_val;
        logic [6:0] et0, et1, et2;
        int         e_cnt;
        logic       e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    free_list_nport_if #(.ALLOC_PORTS(3), .FREE_PORTS(3), .TAG_W(7), .CKPT_W(3), .CNT_W(7)) bus ();

    free_list_nport #(
        .FL_DEPTH(64), .TAG_W(7), .TAG_BASE(32),
        .ALLOC_PORTS(3), .FREE_PORTS(3), .NUM_CKPT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t ma(logic [2:0] req, logic rdy, logic [2:0] val,
                                int t0, int t1, int t2, int cnt, logic ovf);
        vec_t v;
        v.req = req; v.fen = 3'b000; v.ft0 = 7'd0; v.ft1 = 7'd0; v.ft2 = 7'd0;
        v.sv = 1'b0; v.svid = 3'd0; v.rs = 1'b0; v.rsid = 3'd0;
        v.e_rdy = rdy; v.e_val = val;
        v.et0 = 7'(t0); v.et1 = 7'(t1); v.et2 = 7'(t2);
        v.e_cnt = cnt; v.e_ovf = ovf;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.alloc_req       = v.req;
        bus.free_en         = v.fen;
        bus.free_tag[0]     = v.ft0;
        bus.free_tag[1]     = v.ft1;
        bus.free_tag[2]     = v.ft2;
        bus.ckpt_save       = v.sv;
        bus.ckpt_save_id    = v.svid;
        bus.ckpt_restore    = v.rs;
        bus.ckpt_restore_id = v.rsid;
    endtask

    task automatic idle();
        drive(ma(3'b000, 1'b0, 3'b000, 0, 0, 0, 0, 1'b0));
    endtask

    // Compare DUT outputs against the oldest scoreboard entry.
    task automatic compare(string ph, int idx);
        vec_t e;
        string p;
        p = $sformatf("%s[%0d]", ph, idx);
        if (sb.size() == 0) begin
            check({p, " sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({p, " ready"}, int'(bus.alloc_ready), int'(e.e_rdy));
            check({p, " valid"}, int'(bus.alloc_valid), int'(e.e_val));
            check({p, " tag0"},  int'(bus.alloc_tag[0]), int'(e.et0));
            check({p, " tag1"},  int'(bus.alloc_tag[1]), int'(e.et1));
            check({p, " tag2"},  int'(bus.alloc_tag[2]), int'(e.et2));
            check({p, " count"}, int'(bus.count), e.e_cnt);
            check({p, " empty"}, int'(bus.empty), int'(e.e_cnt == 0));
            check({p, " full"},  int'(bus.full),  int'(e.e_cnt == 64));
            check({p, " ovf"},   int'(bus.free_overflow), int'(e.e_ovf));
        end
    endtask

    task automatic apply(vec_t v, string ph, int idx);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        compare(ph, idx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   h;

        // ---- phase A: alloc, checkpoints, drain, wrap, multi-port free ----
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 32, 33, 34, 64, 1'b0));
        tbl_a.push_back(ma(3'b001, 1'b1, 3'b001, 35, 0, 0, 61, 1'b0));
        v = ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 60, 1'b0); v.sv = 1'b1; v.svid = 3'd5;
        tbl_a.push_back(v);
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 36, 37, 38, 60, 1'b0));
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 39, 40, 41, 57, 1'b0));
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 42, 43, 44, 54, 1'b0));
        v = ma(3'b111, 1'b1, 3'b000, 0, 0, 0, 51, 1'b0);
        v.rs = 1'b1; v.rsid = 3'd5; v.sv = 1'b1; v.svid = 3'd2;
        tbl_a.push_back(v);
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 36, 37, 38, 60, 1'b0));
        v = ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 57, 1'b0); v.rs = 1'b1; v.rsid = 3'd2;
        tbl_a.push_back(v);
        tbl_a.push_back(ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b0));
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 32, 33, 34, 64, 1'b0));
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 35, 36, 37, 61, 1'b0));
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 38, 39, 40, 58, 1'b0));
        tbl_a.push_back(ma(3'b001, 1'b1, 3'b001, 41, 0, 0, 55, 1'b0));
        tbl_a.push_back(ma(3'b101, 1'b1, 3'b101, 42, 0, 43, 54, 1'b0));
        for (int k = 0; k < 16; k++) begin
            h = 12 + 3 * k;
            tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 32 + h, 33 + h, 34 + h, 52 - 3 * k, 1'b0));
        end
        tbl_a.push_back(ma(3'b011, 1'b1, 3'b011, 92, 93, 0, 4, 1'b0));
        v = ma(3'b111, 1'b0, 3'b000, 0, 0, 0, 2, 1'b0); v.fen = 3'b001; v.ft0 = 7'd5;
        tbl_a.push_back(v);
        tbl_a.push_back(ma(3'b111, 1'b1, 3'b111, 94, 95, 5, 3, 1'b0));
        v = ma(3'b001, 1'b0, 3'b000, 0, 0, 0, 0, 1'b0);
        v.fen = 3'b110; v.ft0 = 7'd1; v.ft1 = 7'd7; v.ft2 = 7'd9;
        tbl_a.push_back(v);
        tbl_a.push_back(ma(3'b010, 1'b1, 3'b010, 0, 7, 0, 2, 1'b0));
        tbl_a.push_back(ma(3'b100, 1'b1, 3'b100, 0, 0, 9, 1, 1'b0));
        tbl_a.push_back(ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 0, 1'b0));

        // ---- phase B (after mid-run reset): overflow at full ----
        v = ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b0); v.fen = 3'b001; v.ft0 = 7'd3;
        tbl_b.push_back(v);
        tbl_b.push_back(ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b1));
        tbl_b.push_back(ma(3'b111, 1'b1, 3'b111, 32, 33, 34, 64, 1'b1));
        v = ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 61, 1'b1);
        v.fen = 3'b111; v.ft0 = 7'd32; v.ft1 = 7'd33; v.ft2 = 7'd34;
        tbl_b.push_back(v);
        tbl_b.push_back(ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b1));
        v = ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b1); v.fen = 3'b010; v.ft1 = 7'd9;
        tbl_b.push_back(v);
        tbl_b.push_back(ma(3'b000, 1'b1, 3'b000, 0, 0, 0, 64, 1'b1));
        tbl_b.push_back(ma(3'b111, 1'b1, 3'b111, 35, 36, 37, 64, 1'b1));

        // ---- initial reset ----
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset count", int'(bus.count), 64);
        check("reset full",  int'(bus.full), 1);
        check("reset empty", int'(bus.empty), 0);
        check("reset ovf",   int'(bus.free_overflow), 0);
        check("reset valid", int'(bus.alloc_valid), 0);
        rst_n = 1'b1;

        foreach (tbl_a[i]) apply(tbl_a[i], "A", i);

        // ---- reset in the middle of operation ----
        idle();
        rst_n = 1'b0;
        #2;
        check("midrst count", int'(bus.count), 64);
        check("midrst full",  int'(bus.full), 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl_b[i]) apply(tbl_b[i], "B", i);

        // ---- overflow flag clears only on reset ----
        idle();
        @(negedge clk);
        check("ovf sticky", int'(bus.free_overflow), 1);
        rst_n = 1'b0;
        #2;
        check("ovf cleared", int'(bus.free_overflow), 0);
        check("final count", int'(bus.count), 64);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
